// File: rtl/aer_spike_fifo_if.sv
// Handshake bundle between the AER encoder, the spike FIFO and the SNN engine input.
// The slave view is the FIFO itself; the master view is the surrounding logic.
interface aer_spike_fifo_if #(
    parameter int unsigned TIME_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              i_aer_req;
    logic              o_aer_ack;
    logic [TIME_W-1:0] i_aer_time;
    logic [ADDR_W-1:0] i_aer_addr;
    logic              i_encoder_done;
    logic              o_spk_valid;
    logic              i_spk_ready;
    logic [TIME_W-1:0] o_spk_time;
    logic [ADDR_W-1:0] o_spk_addr;

    modport slave (
        input  i_aer_req, i_aer_time, i_aer_addr, i_encoder_done, i_spk_ready,
        output o_aer_ack, o_spk_valid, o_spk_time, o_spk_addr
    );

    modport master (
        output i_aer_req, i_aer_time, i_aer_addr, i_encoder_done, i_spk_ready,
        input  o_aer_ack, o_spk_valid, o_spk_time, o_spk_addr
    );
endinterface

// File: rtl/aer_spike_fifo.sv
// First-word-fall-through event buffer between the AER encoder and the SNN engine.
// Emits a frame-done pulse once every event of the frame has drained, plus the frame's event count.
module aer_spike_fifo #(
    parameter int unsigned VEC_LEN = 160,
    parameter int unsigned TIME_W  = 8,
    parameter int unsigned ADDR_W  = $clog2(VEC_LEN),
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             local_clk,
    input  logic             rst,
    aer_spike_fifo_if.slave  io_aer,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_frame_done,
    output logic [ADDR_W:0]  o_frame_events,
    output logic             o_addr_err
);
    localparam int unsigned      AW         = $clog2(DEPTH);
    localparam logic [ADDR_W:0]  LP_VEC_LEN = (ADDR_W + 1)'(VEC_LEN);
    localparam logic [CNT_W-1:0] LP_DEPTH   = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    logic [TIME_W-1:0] r_mem_time [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W:0]   r_acc;
    logic [ADDR_W:0]   r_frame_events;
    logic              r_addr_err;
    state_t            r_state;
    state_t            w_state_next;

    logic w_full;
    logic w_valid;
    logic w_xfer_in;
    logic w_addr_ok;
    logic w_push;
    logic w_pop;
    logic w_frame_done;

    // Ack depends only on the registered count, so a pop cannot free a slot in the same cycle.
    assign w_full    = (r_count == LP_DEPTH);
    assign w_valid   = (r_count != '0);
    assign w_xfer_in = io_aer.i_aer_req & ~w_full;
    assign w_addr_ok = ({1'b0, io_aer.i_aer_addr} < LP_VEC_LEN);
    assign w_push    = w_xfer_in & w_addr_ok;
    assign w_pop     = w_valid & io_aer.i_spk_ready;

    assign io_aer.o_aer_ack   = w_xfer_in;
    assign io_aer.o_spk_valid = w_valid;
    assign io_aer.o_spk_time  = w_valid ? r_mem_time[r_rd_ptr] : '0;
    assign io_aer.o_spk_addr  = w_valid ? r_mem_addr[r_rd_ptr] : '0;

    assign o_count        = r_count;
    assign o_full         = w_full;
    assign o_frame_done   = w_frame_done;
    assign o_frame_events = r_frame_events;
    assign o_addr_err     = r_addr_err;

    always_ff @(posedge local_clk) begin
        if (w_push) begin
            r_mem_time[r_wr_ptr] <= io_aer.i_aer_time;
            r_mem_addr[r_wr_ptr] <= io_aer.i_aer_addr;
        end
    end

    always_ff @(posedge local_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_xfer_in && !w_addr_ok) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_done = 1'b0;
        unique case (r_state)
            S_RUN: begin
                if (io_aer.i_encoder_done) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_count == '0) && !w_push) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_frame_done = 1'b1;
                w_state_next = S_RUN;
            end
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge local_clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_RUN;
            r_acc          <= '0;
            r_frame_events <= '0;
        end else begin
            r_state <= w_state_next;
            // A push landing in the done cycle opens the next frame's count.
            if (r_state == S_DONE) begin
                r_frame_events <= r_acc;
                r_acc          <= (ADDR_W + 1)'(w_push);
            end else if (w_push) begin
                r_acc <= r_acc + (ADDR_W + 1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_aer_spike_fifo.sv
// Self-checking bench for aer_spike_fifo: vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_aer_spike_fifo;
    localparam int unsigned VEC_LEN = 160;
    localparam int unsigned TIME_W  = 8;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned CNT_W   = 5;

    typedef struct packed {
        logic [7:0] t;
        logic [7:0] a;
    } ev_t;

    typedef struct {
        logic [7:0] t;
        logic [7:0] a;
        logic       ack;
        int         cnt;
        logic       err;
    } vec_t;

    logic             local_clk = 1'b0;
    logic             rst       = 1'b1;
    logic [CNT_W-1:0] o_count;
    logic             o_full;
    logic             o_frame_done;
    logic [ADDR_W:0]  o_frame_events;
    logic             o_addr_err;

    aer_spike_fifo_if #(.TIME_W(TIME_W), .ADDR_W(ADDR_W)) aer_bus ();

    aer_spike_fifo #(
        .VEC_LEN(VEC_LEN),
        .TIME_W (TIME_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .local_clk     (local_clk),
        .rst           (rst),
        .io_aer        (aer_bus),
        .o_count       (o_count),
        .o_full        (o_full),
        .o_frame_done  (o_frame_done),
        .o_frame_events(o_frame_events),
        .o_addr_err    (o_addr_err)
    );

    always #5 local_clk = ~local_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge local_clk);
        #1;
    endtask

    task automatic set_idle();
        aer_bus.i_aer_req      = 1'b0;
        aer_bus.i_aer_time     = '0;
        aer_bus.i_aer_addr     = '0;
        aer_bus.i_encoder_done = 1'b0;
        aer_bus.i_spk_ready    = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        @(posedge local_clk);
        @(posedge local_clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_set(input int t, input int a);
        aer_bus.i_aer_req  = 1'b1;
        aer_bus.i_aer_time = 8'(t);
        aer_bus.i_aer_addr = 8'(a);
    endtask

    // Returns the number of whole cycles waited before o_frame_done, or -1 on timeout.
    task automatic wait_fd(input int max_cyc, output int lat);
        lat = -1;
        for (int c = 0; c < max_cyc; c++) begin
            #1;
            if (o_frame_done) begin
                lat = c;
                break;
            end
            tick();
        end
    endtask

    vec_t vecs [8];
    ev_t  exp_q [$];
    ev_t  mdl_q [$];
    int   lat;
    int   fd_seen;
    int   acc;
    logic mdl_err;
    logic pending;
    logic exp_ack;
    logic [7:0] cur_t;
    logic [7:0] cur_a;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h10, 8'd0,   1'b1, 1, 1'b0};
        vecs[1] = '{8'hF0, 8'd159, 1'b1, 2, 1'b0};
        vecs[2] = '{8'h20, 8'd160, 1'b1, 2, 1'b1};
        vecs[3] = '{8'h7F, 8'd200, 1'b1, 2, 1'b1};
        vecs[4] = '{8'h80, 8'd255, 1'b1, 2, 1'b1};
        vecs[5] = '{8'h01, 8'd5,   1'b1, 3, 1'b1};
        vecs[6] = '{8'hFF, 8'd200, 1'b1, 3, 1'b1};
        vecs[7] = '{8'h3C, 8'd100, 1'b1, 4, 1'b1};

        // Reset state.
        do_reset();
        #1;
        chk("rst_count", o_count, 0);
        chk("rst_full", o_full, 0);
        chk("rst_valid", aer_bus.o_spk_valid, 0);
        chk("rst_frame_done", o_frame_done, 0);
        chk("rst_frame_events", o_frame_events, 0);
        chk("rst_addr_err", o_addr_err, 0);
        chk("rst_spk_time", aer_bus.o_spk_time, 0);
        chk("rst_spk_addr", aer_bus.o_spk_addr, 0);
        chk("rst_ack_idle", aer_bus.o_aer_ack, 0);

        // Eight events streamed with ready high; each shows at the head one cycle after its ack.
        aer_bus.i_spk_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_set(i, i);
            #1;
            chk("s8_ack", aer_bus.o_aer_ack, 1);
            if (i == 0) begin
                chk("s8_valid_first", aer_bus.o_spk_valid, 0);
            end else begin
                chk("s8_valid", aer_bus.o_spk_valid, 1);
                chk("s8_time", aer_bus.o_spk_time, i - 1);
                chk("s8_addr", aer_bus.o_spk_addr, i - 1);
            end
            tick();
        end
        aer_bus.i_aer_req      = 1'b0;
        aer_bus.i_encoder_done = 1'b1;
        #1;
        chk("s8_last_time", aer_bus.o_spk_time, 7);
        chk("s8_fd_early", o_frame_done, 0);
        tick();
        aer_bus.i_encoder_done = 1'b0;
        wait_fd(20, lat);
        chk("s8_fd_latency", lat, 1);
        chk("s8_fd_count", o_count, 0);
        tick();
        #1;
        chk("s8_frame_events", o_frame_events, 8);
        chk("s8_fd_single", o_frame_done, 0);

        // Done pulse on an empty FIFO.
        aer_bus.i_encoder_done = 1'b1;
        tick();
        aer_bus.i_encoder_done = 1'b0;
        #1;
        chk("edone_t1", o_frame_done, 0);
        tick();
        #1;
        chk("edone_t2", o_frame_done, 1);
        tick();
        #1;
        chk("edone_t3", o_frame_done, 0);
        chk("edone_events", o_frame_events, 0);

        // Fill to full with ready low, then the 17th event around a pop.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push_set(i, i);
            #1;
            chk("fill_ack", aer_bus.o_aer_ack, 1);
            tick();
        end
        push_set(16, 16);
        #1;
        chk("fill_count16", o_count, 16);
        chk("fill_full", o_full, 1);
        chk("fill_ack17", aer_bus.o_aer_ack, 0);
        tick();
        aer_bus.i_spk_ready = 1'b1;
        #1;
        chk("fullpop_ack", aer_bus.o_aer_ack, 0);
        chk("fullpop_head", aer_bus.o_spk_time, 0);
        tick();
        aer_bus.i_spk_ready = 1'b0;
        #1;
        chk("fullpop_count15", o_count, 15);
        chk("fullpop_ack_next", aer_bus.o_aer_ack, 1);
        chk("fullpop_head1", aer_bus.o_spk_time, 1);
        tick();
        #1;
        chk("refill_count16", o_count, 16);
        chk("refill_full", o_full, 1);
        aer_bus.i_aer_req   = 1'b0;
        aer_bus.i_spk_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            chk("fill_drain_valid", aer_bus.o_spk_valid, 1);
            chk("fill_drain_time", aer_bus.o_spk_time, i);
            chk("fill_drain_addr", aer_bus.o_spk_addr, i);
            tick();
        end
        #1;
        chk("fill_empty", aer_bus.o_spk_valid, 0);

        // Address-range table with ready low.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push_set(vecs[i].t, vecs[i].a);
            #1;
            chk("tbl_ack", aer_bus.o_aer_ack, vecs[i].ack);
            tick();
            #1;
            chk("tbl_count", o_count, vecs[i].cnt);
            chk("tbl_err", o_addr_err, vecs[i].err);
            if (vecs[i].a < VEC_LEN) exp_q.push_back('{vecs[i].t, vecs[i].a});
        end
        aer_bus.i_aer_req      = 1'b0;
        aer_bus.i_spk_ready    = 1'b1;
        aer_bus.i_encoder_done = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            chk("tbl_out_valid", aer_bus.o_spk_valid, 1);
            chk("tbl_out_time", aer_bus.o_spk_time, exp_q[i].t);
            chk("tbl_out_addr", aer_bus.o_spk_addr, exp_q[i].a);
            tick();
            aer_bus.i_encoder_done = 1'b0;
        end
        wait_fd(20, lat);
        chk("tbl_fd_latency", lat, 1);
        tick();
        #1;
        chk("tbl_frame_events", o_frame_events, 4);
        chk("tbl_err_sticky", o_addr_err, 1);

        // Reset with five entries stored while draining.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_set(i + 40, i + 40);
            tick();
        end
        aer_bus.i_aer_req      = 1'b0;
        aer_bus.i_encoder_done = 1'b1;
        tick();
        aer_bus.i_encoder_done = 1'b0;
        #1;
        chk("mrst_pre_count", o_count, 5);
        rst = 1'b1;
        #1;
        chk("mrst_count", o_count, 0);
        chk("mrst_valid", aer_bus.o_spk_valid, 0);
        chk("mrst_addr", aer_bus.o_spk_addr, 0);
        tick();
        rst     = 1'b0;
        fd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_frame_done) fd_seen++;
        end
        chk("mrst_no_fd", fd_seen, 0);
        aer_bus.i_encoder_done = 1'b1;
        tick();
        aer_bus.i_encoder_done = 1'b0;
        wait_fd(20, lat);
        chk("mrst_run_fd_latency", lat, 1);
        tick();

        // Randomized traffic against a queue model.
        do_reset();
        mdl_q.delete();
        acc     = 0;
        mdl_err = 1'b0;
        pending = 1'b0;
        cur_t   = '0;
        cur_a   = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!pending && ($urandom_range(0, 3) != 0)) begin
                pending = 1'b1;
                cur_t   = 8'($urandom);
                cur_a   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(160, 255))
                                                      : 8'($urandom_range(0, 159));
            end
            aer_bus.i_aer_req   = pending;
            aer_bus.i_aer_time  = cur_t;
            aer_bus.i_aer_addr  = cur_a;
            aer_bus.i_spk_ready = ($urandom_range(0, 99) < (((cyc / 100) % 2) ? 85 : 25));
            #1;
            exp_ack = pending && (mdl_q.size() < DEPTH);
            chk("rnd_ack", aer_bus.o_aer_ack, exp_ack);
            chk("rnd_valid", aer_bus.o_spk_valid, mdl_q.size() > 0);
            chk("rnd_count", o_count, mdl_q.size());
            chk("rnd_full", o_full, mdl_q.size() == DEPTH);
            chk("rnd_err", o_addr_err, mdl_err);
            if (mdl_q.size() > 0) begin
                chk("rnd_time", aer_bus.o_spk_time, mdl_q[0].t);
                chk("rnd_addr", aer_bus.o_spk_addr, mdl_q[0].a);
            end
            if (aer_bus.i_spk_ready && (mdl_q.size() > 0)) void'(mdl_q.pop_front());
            if (exp_ack) begin
                if (cur_a < VEC_LEN) begin
                    mdl_q.push_back('{cur_t, cur_a});
                    acc++;
                end else begin
                    mdl_err = 1'b1;
                end
                pending = 1'b0;
            end
            tick();
        end
        aer_bus.i_aer_req      = 1'b0;
        aer_bus.i_spk_ready    = 1'b1;
        aer_bus.i_encoder_done = 1'b1;
        tick();
        aer_bus.i_encoder_done = 1'b0;
        wait_fd(40, lat);
        chk("rnd_fd_seen", lat >= 0, 1);
        tick();
        #1;
        chk("rnd_frame_events", o_frame_events, acc);
        chk("rnd_drained", o_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
